vx_csr_rmw_ctrl: RTL and testbench
==================================

// Module: vx_csr_rmw_ctrl
// PURPOSE
// Initiator side of the core CSR access port. Accepts one decoded CSR instruction at a time
// (CSRRW/CSRRS/CSRRC, register or 5-bit immediate source) and drives the read port and then
// the write port of the per-core CSR data block as a read-modify-write. Returns the old CSR
// value for rd on a valid/ready response. Sits between the issue stage and the CSR data block.
// PARAMETERS
// CSR_ADDR_BITS  12  CSR address width
// NW_BITS        2   warp-id width
// UUID_BITS      44  instruction uuid width (debug tag, passed through)
// PORTS
// clk            in   1              clock, all state on rising edge
// reset_n        in   1              asynchronous, active-low reset
// req_valid      in   1              request valid
// req_ready      out  1              request ready (high only in IDLE)
// req_uuid       in   UUID_BITS      instruction uuid
// req_wid        in   NW_BITS        issuing warp
// req_addr       in   CSR_ADDR_BITS  CSR address
// req_op         in   2              01=RW 10=RS(set) 11=RC(clear) 00=illegal
// req_use_imm    in   1              source is req_imm (zero-extended) instead of req_rs1_data
// req_imm        in   5              immediate / rs1 index (for RS/RC write suppression)
// req_rs1_data   in   32             rs1 value
// req_rd_nz      in   1              rd != x0
// read_enable    out  1              CSR read strobe
// read_uuid      out  UUID_BITS      uuid for read
// read_addr      out  CSR_ADDR_BITS  read address
// read_wid       out  NW_BITS        read warp
// read_data      in   32             combinational read data, valid the same cycle as read_enable
// write_enable   out  1              CSR write strobe, one cycle
// write_uuid     out  UUID_BITS      uuid for write
// write_addr     out  CSR_ADDR_BITS  write address
// write_wid      out  NW_BITS        write warp
// write_data     out  32             new CSR value
// rsp_valid      out  1              response valid
// rsp_ready      in   1              response ready
// rsp_uuid       out  UUID_BITS      uuid of response
// rsp_wid        out  NW_BITS        warp of response
// rsp_data       out  32             old CSR value (rd write data)
// rsp_illegal    out  1              op 00, or write attempted to read-only CSR
// busy           out  1              state != IDLE
// BEHAVIOUR
// - Reset (reset_n low, async): state=IDLE; every output 0 (req_ready is 0 while reset_n is low,
//   1 from the first cycle after release); all latched request fields cleared.
// - FSM: IDLE -> READ -> {WRITE ->} RESP -> IDLE.
// - IDLE: req_ready=1. Accept when req_valid is high; latch all req_* fields. src = use_imm ? {27'b0,imm} : rs1_data.
// - do_read  = (op!=00) && !(op==RW && !rd_nz).
// - do_write = (op==RW) || (op!=00 && src_idx_nz). src_idx_nz = (req_imm!=0) for RS/RC in both
//   register and immediate forms: rs1 index x0, or a zero immediate, suppresses the write.
// - READ (1 cycle): read_enable=do_read; addr/wid/uuid driven from latches. old = do_read ? read_data : 0,
//   registered. new: RW=src, RS=old|src, RC=old&~src.
//   ro = (addr[11:10]==2'b11). ro && do_write sets illegal and cancels the write.
//   op==00 sets illegal, with no read and no write.
//   Next state is WRITE if the write is still enabled, else RESP.
// - WRITE (1 cycle): write_enable=1 with write_data=new, then RESP.
// - RESP: rsp_valid=1 and rsp_* held stable until rsp_ready is high in the same cycle, then IDLE.
//   A new request is accepted no earlier than the cycle after RESP exits (no overlap).
// - Latency, accept at cycle T: read at T+1; write at T+2; rsp_valid from T+3, or from T+2 when there is no write.
// - read_enable and write_enable are never both high. write_enable is never high outside WRITE.
// - Reset mid-operation aborts without a write. If reset hits in WRITE, the strobe drops asynchronously.
// - uuid/wid/addr are passed through unmodified. rsp_data holds old even when rsp_illegal is set.
// TESTING
// - RW: addr=0x340, rs1=0xDEADBEEF, rd_nz=1, CSR holds 0x12 -> read T+1, write 0xDEADBEEF T+2, rsp_data=0x12 T+3.
// - RS imm=5'h03, CSR=0x10 -> write_data=0x13. RC reg rs1=0xF0, CSR=0xFF -> write_data=0x0F.
// - RS imm=0 -> no write_enable, rsp_valid at T+2 with rsp_data=CSR. RW rd_nz=0 -> no read_enable, rsp_data=0.
// - RW to 0xC00 (read-only) -> no write, rsp_illegal=1. op=00 -> no strobes, rsp_illegal=1, rsp_data=0.
// - rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0, busy=1; back-to-back requests accepted right after the handshake.
// - Assert reset_n low during WRITE -> write_enable drops immediately, state IDLE, all outputs 0.

Source files
------------

// File: rtl/vx_csr_rmw_ctrl_if.sv
// Bundle of request, CSR read/write port and response signals for the CSR read-modify-write initiator.
interface vx_csr_rmw_ctrl_if #(
    parameter int CSR_ADDR_BITS = 12,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44
);
    logic                     req_valid;
    logic                     req_ready;
    logic [UUID_BITS-1:0]     req_uuid;
    logic [NW_BITS-1:0]       req_wid;
    logic [CSR_ADDR_BITS-1:0] req_addr;
    logic [1:0]               req_op;
    logic                     req_use_imm;
    logic [4:0]               req_imm;
    logic [31:0]              req_rs1_data;
    logic                     req_rd_nz;

    logic                     read_enable;
    logic [UUID_BITS-1:0]     read_uuid;
    logic [CSR_ADDR_BITS-1:0] read_addr;
    logic [NW_BITS-1:0]       read_wid;
    logic [31:0]              read_data;

    logic                     write_enable;
    logic [UUID_BITS-1:0]     write_uuid;
    logic [CSR_ADDR_BITS-1:0] write_addr;
    logic [NW_BITS-1:0]       write_wid;
    logic [31:0]              write_data;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [UUID_BITS-1:0]     rsp_uuid;
    logic [NW_BITS-1:0]       rsp_wid;
    logic [31:0]              rsp_data;
    logic                     rsp_illegal;

    logic                     busy;

    modport master (
        input  req_valid, req_uuid, req_wid, req_addr, req_op, req_use_imm, req_imm,
               req_rs1_data, req_rd_nz, read_data, rsp_ready,
        output req_ready, read_enable, read_uuid, read_addr, read_wid,
               write_enable, write_uuid, write_addr, write_wid, write_data,
               rsp_valid, rsp_uuid, rsp_wid, rsp_data, rsp_illegal, busy
    );

    modport slave (
        output req_valid, req_uuid, req_wid, req_addr, req_op, req_use_imm, req_imm,
               req_rs1_data, req_rd_nz, read_data, rsp_ready,
        input  req_ready, read_enable, read_uuid, read_addr, read_wid,
               write_enable, write_uuid, write_addr, write_wid, write_data,
               rsp_valid, rsp_uuid, rsp_wid, rsp_data, rsp_illegal, busy
    );
endinterface

// File: rtl/vx_csr_rmw_ctrl.sv
// CSR read-modify-write initiator: accepts one CSRRW/CSRRS/CSRRC at a time, reads the CSR,
// optionally writes the modified value, and returns the old value as the rd response.
module vx_csr_rmw_ctrl #(
    parameter int CSR_ADDR_BITS = 12,
    parameter int NW_BITS       = 2,
    parameter int UUID_BITS     = 44
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vx_csr_rmw_ctrl_if.master     bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    state_e                   state_q, state_d;
    logic                     ready_q;
    logic [UUID_BITS-1:0]     uuid_q;
    logic [NW_BITS-1:0]       wid_q;
    logic [CSR_ADDR_BITS-1:0] addr_q;
    logic [1:0]               op_q;
    logic [31:0]              src_q;
    logic                     do_read_q;
    logic                     do_write_q;
    logic [31:0]              old_q;
    logic [31:0]              new_q;
    logic                     illegal_q;

    logic                     accept_s;
    logic                     ro_s;
    logic                     wr_s;
    logic                     ill_s;
    logic [31:0]              old_s;

    function automatic logic [31:0] calc_new(input logic [1:0] op, input logic [31:0] old_v,
                                             input logic [31:0] src_v);
        logic [31:0] res;
        case (op)
            OP_RW:   res = src_v;
            OP_RS:   res = old_v | src_v;
            OP_RC:   res = old_v & ~src_v;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // ready_q mirrors "next state is IDLE" so it stays low while reset_n is asserted.
    assign accept_s = bus.req_valid && ready_q;
    assign ro_s     = (addr_q[CSR_ADDR_BITS-1 -: 2] == 2'b11);
    assign wr_s     = do_write_q && !ro_s;
    assign ill_s    = (op_q == OP_ILL) || (ro_s && do_write_q);
    assign old_s    = do_read_q ? bus.read_data : 32'h0000_0000;

    // State register and registered request-ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Request latches at accept; old/new/illegal captured in the READ cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uuid_q     <= '0;
            wid_q      <= '0;
            addr_q     <= '0;
            op_q       <= 2'b00;
            src_q      <= 32'h0000_0000;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
            old_q      <= 32'h0000_0000;
            new_q      <= 32'h0000_0000;
            illegal_q  <= 1'b0;
        end else if (accept_s) begin
            uuid_q     <= bus.req_uuid;
            wid_q      <= bus.req_wid;
            addr_q     <= bus.req_addr;
            op_q       <= bus.req_op;
            src_q      <= bus.req_use_imm ? {27'd0, bus.req_imm} : bus.req_rs1_data;
            do_read_q  <= (bus.req_op != OP_ILL) && !((bus.req_op == OP_RW) && !bus.req_rd_nz);
            // A zero rs1 index or zero immediate suppresses the write for RS/RC.
            do_write_q <= (bus.req_op == OP_RW) ||
                          ((bus.req_op != OP_ILL) && (bus.req_imm != 5'd0));
        end else if (state_q == ST_READ) begin
            old_q      <= old_s;
            new_q      <= calc_new(op_q, old_s, src_q);
            illegal_q  <= ill_s;
            do_write_q <= wr_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_s) state_d = ST_READ; else state_d = ST_IDLE;
            ST_READ:  if (wr_s) state_d = ST_WRITE; else state_d = ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE; else state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and latched fields; strobes fall with the async reset.
    always_comb begin
        bus.req_ready    = ready_q;
        bus.busy         = (state_q != ST_IDLE);
        bus.read_enable  = (state_q == ST_READ) && do_read_q;
        bus.read_uuid    = uuid_q;
        bus.read_addr    = addr_q;
        bus.read_wid     = wid_q;
        bus.write_enable = (state_q == ST_WRITE);
        bus.write_uuid   = uuid_q;
        bus.write_addr   = addr_q;
        bus.write_wid    = wid_q;
        bus.write_data   = new_q;
        bus.rsp_valid    = (state_q == ST_RESP);
        bus.rsp_uuid     = uuid_q;
        bus.rsp_wid      = wid_q;
        bus.rsp_data     = old_q;
        bus.rsp_illegal  = illegal_q;
    end
endmodule

// File: tb/tb_vx_csr_rmw_ctrl.sv
// Directed, table-driven bench for the CSR read-modify-write initiator.
module tb_vx_csr_rmw_ctrl;
    logic        clk;
    logic        reset_n;
    logic [31:0] csr_val;
    int          n_checks;
    int          n_errors;

    vx_csr_rmw_ctrl_if #(.CSR_ADDR_BITS(12), .NW_BITS(2), .UUID_BITS(44)) bus ();

    vx_csr_rmw_ctrl #(.CSR_ADDR_BITS(12), .NW_BITS(2), .UUID_BITS(44)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    assign bus.read_data = csr_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        use_imm;
        logic [4:0]  imm;
        logic [31:0] rs1;
        logic        rd_nz;
        logic [11:0] addr;
        logic [31:0] csr;
        logic        exp_read;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic        exp_ill;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] uuid_of(input int idx);
        logic [43:0] u;
        u = 44'hA5A_0000_0000 + 44'(idx);
        return u;
    endfunction

    task automatic drive_req(input vec_t v, input int idx);
        logic [31:0] i32;
        i32 = 32'(idx);
        bus.req_valid    = 1'b1;
        bus.req_uuid     = uuid_of(idx);
        bus.req_wid      = i32[1:0];
        bus.req_addr     = v.addr;
        bus.req_op       = v.op;
        bus.req_use_imm  = v.use_imm;
        bus.req_imm      = v.imm;
        bus.req_rs1_data = v.rs1;
        bus.req_rd_nz    = v.rd_nz;
        csr_val          = v.csr;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] i32;
        i32 = 32'(idx);
        @(negedge clk);
        drive_req(v, idx);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("read_enable", 64'(bus.read_enable), 64'(v.exp_read));
        chk("no_write_in_read", 64'(bus.write_enable), 64'd0);
        if (v.exp_read) chk("read_addr", 64'(bus.read_addr), 64'(v.addr));
        @(negedge clk);
        if (v.exp_write) begin
            chk("write_enable", 64'(bus.write_enable), 64'd1);
            chk("write_data", 64'(bus.write_data), 64'(v.exp_wdata));
            chk("write_addr", 64'(bus.write_addr), 64'(v.addr));
            chk("rsp_early", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
        end else begin
            chk("no_write", 64'(bus.write_enable), 64'd0);
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_data", 64'(bus.rsp_data), 64'(v.exp_rsp));
        chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(v.exp_ill));
        chk("rsp_uuid", 64'(bus.rsp_uuid), 64'(uuid_of(idx)));
        chk("rsp_wid", 64'(bus.rsp_wid), 64'(i32[1:0]));
        chk("write_in_resp", 64'(bus.write_enable), 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("busy_after", 64'(bus.busy), 64'd0);
        chk("rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        csr_val = 32'h0;
        bus.req_valid = 1'b0; bus.req_uuid = '0; bus.req_wid = 2'd0; bus.req_addr = 12'h0;
        bus.req_op = 2'b00; bus.req_use_imm = 1'b0; bus.req_imm = 5'd0;
        bus.req_rs1_data = 32'h0; bus.req_rd_nz = 1'b0; bus.rsp_ready = 1'b0;

        //        op     imm   immv   rs1           rdnz  addr     csr           rd    wr    wdata         ill   rsp
        vecs[0]  = '{2'b01, 1'b0, 5'd1,  32'hDEADBEEF, 1'b1, 12'h340, 32'h00000012, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h00000012};
        vecs[1]  = '{2'b10, 1'b1, 5'h03, 32'hFFFFFFFF, 1'b1, 12'h300, 32'h00000010, 1'b1, 1'b1, 32'h00000013, 1'b0, 32'h00000010};
        vecs[2]  = '{2'b11, 1'b0, 5'd7,  32'h000000F0, 1'b1, 12'h301, 32'h000000FF, 1'b1, 1'b1, 32'h0000000F, 1'b0, 32'h000000FF};
        vecs[3]  = '{2'b10, 1'b1, 5'd0,  32'h00000000, 1'b1, 12'h302, 32'h0000ABCD, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h0000ABCD};
        vecs[4]  = '{2'b01, 1'b0, 5'd2,  32'h00000055, 1'b0, 12'h341, 32'h00000099, 1'b0, 1'b1, 32'h00000055, 1'b0, 32'h00000000};
        vecs[5]  = '{2'b01, 1'b0, 5'd3,  32'h00000001, 1'b1, 12'hC00, 32'h00000777, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000777};
        vecs[6]  = '{2'b00, 1'b0, 5'd4,  32'h11111111, 1'b1, 12'h305, 32'h00003333, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000000};
        vecs[7]  = '{2'b11, 1'b0, 5'd0,  32'h0000FFFF, 1'b1, 12'h306, 32'h00001234, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00001234};
        vecs[8]  = '{2'b10, 1'b0, 5'd0,  32'h00000F0F, 1'b1, 12'hC01, 32'h00000042, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000042};
        vecs[9]  = '{2'b10, 1'b0, 5'd2,  32'h00000F00, 1'b1, 12'h7C0, 32'h0000F00F, 1'b1, 1'b1, 32'h0000FF0F, 1'b0, 32'h0000F00F};
        vecs[10] = '{2'b11, 1'b1, 5'd1,  32'h00000000, 1'b1, 12'hC02, 32'h00000008, 1'b1, 1'b0, 32'h00000000, 1'b1, 32'h00000008};

        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_read_en", 64'(bus.read_enable), 64'd0);
        chk("rst_write_en", 64'(bus.write_enable), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready_clk", 64'(bus.req_ready), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_rst", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Stalled response followed by a back-to-back request.
        @(negedge clk);
        drive_req(vecs[1], 20);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive_req(vecs[0], 21);
        bus.req_valid = 1'b0;
        csr_val = 32'h0000_0010;
        for (int c = 0; c < 5; c++) begin
            chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("stall_rsp_data", 64'(bus.rsp_data), 64'h10);
            chk("stall_rsp_uuid", 64'(bus.rsp_uuid), 64'(uuid_of(20)));
            chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
            chk("stall_busy", 64'(bus.busy), 64'd1);
            chk("stall_no_write", 64'(bus.write_enable), 64'd0);
            if (c == 4) begin
                bus.req_valid = 1'b1;
                bus.rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        csr_val = 32'h0000_0012;
        chk("b2b_req_ready", 64'(bus.req_ready), 64'd1);
        chk("b2b_rsp_dropped", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_read_en", 64'(bus.read_enable), 64'd1);
        chk("b2b_read_addr", 64'(bus.read_addr), 64'h340);
        @(negedge clk);
        chk("b2b_write_data", 64'(bus.write_data), 64'hDEADBEEF);
        @(negedge clk);
        chk("b2b_rsp_data", 64'(bus.rsp_data), 64'h12);
        chk("b2b_rsp_uuid", 64'(bus.rsp_uuid), 64'(uuid_of(21)));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Reset asserted while the write strobe is high.
        drive_req(vecs[0], 30);
        bus.req_addr = 12'h342;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_write_en", 64'(bus.write_enable), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_write_en", 64'(bus.write_enable), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_write_data", 64'(bus.write_data), 64'd0);
        chk("mid_rst_read_addr", 64'(bus.read_addr), 64'd0);
        chk("mid_rst_rsp_uuid", 64'(bus.rsp_uuid), 64'd0);
        chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("post_rst_write_en", 64'(bus.write_enable), 64'd0);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
